fetch_sequencer: RTL and testbench

//  Sequences the program counter that addresses the instruction ROM.

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_sequencer_checker.sv | 23 ++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// XLEN must match the DATA_WIDTH parameter of fetch_sequencer.
package mips_fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] INSTR_NOP = {XLEN{1'b0}};

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr}. A pop in the same cycle as a flush is
// honoured first; the flush then empties the queue and suppresses any push.
module fetch_queue
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_s;
  logic [1:0]   after_pop_s;

  // next-state for the two slots and the occupancy count
  always_comb begin
    entry0_d    = entry0_q;
    entry1_d    = entry1_q;
    count_d     = count_q;
    pop_s       = pop && (count_q != 2'd0);
    after_pop_s = count_q - {1'b0, pop_s};
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop_s) begin
        entry0_d = entry1_q;
      end else begin
        entry0_d = entry0_q;
      end
      if (push && (after_pop_s < 2'd2)) begin
        if (after_pop_s == 2'd0) begin
          entry0_d = push_entry;
        end else begin
          entry1_d = push_entry;
        end
        count_d = after_pop_s + 2'd1;
      end else begin
        count_d = after_pop_s;
      end
    end
  end

  // queue storage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '{pc: {XLEN{1'b0}}, instr: INSTR_NOP};
      entry1_q <= '{pc: {XLEN{1'b0}}, instr: INSTR_NOP};
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/fetch_sequencer_checker.sv
// Invariants of the fetch sequencer outputs and queue occupancy.
module fetch_sequencer_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  valid,
  input logic [DATA_WIDTH-1:0] instr,
  input logic [DATA_WIDTH-1:0] imem_addr,
  input logic [1:0]            count
);

  a_nop_when_invalid: assert property (@(posedge clk) disable iff (!rst_n)
    !valid |-> (instr == {DATA_WIDTH{1'b0}}));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(count) <= 32'(QUEUE_DEPTH)));

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_addr[1:0] == 2'b00));

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer for the instruction ROM: fetches one word per cycle into a
// 2-entry queue and hands instructions to decode over valid/ready.
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = {DATA_WIDTH{1'b0}},
  parameter int                    QUEUE_DEPTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_redirect_valid,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic [DATA_WIDTH-1:0] i_imem_instr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_fault
);

  localparam logic [DATA_WIDTH-1:0] PC_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);

  function automatic logic pc_in_range(input logic [DATA_WIDTH-1:0] pc);
    return pc < PC_LIMIT;
  endfunction

  function automatic logic pc_aligned(input logic [DATA_WIDTH-1:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            q_count_s;
  fetch_entry_t          head_s;
  fetch_entry_t          push_entry_s;
  logic                  deq_s, has_slot_s, fetch_s, range_fault_s;
  logic                  redirect_ok_s, redirect_bad_s;

  // handshake, redirect classification and fetch decision
  always_comb begin
    deq_s          = (q_count_s != 2'd0) && i_ready;
    redirect_ok_s  = i_redirect_valid && pc_aligned(i_redirect_pc) && pc_in_range(i_redirect_pc);
    redirect_bad_s = i_redirect_valid && !redirect_ok_s;
    has_slot_s     = (q_count_s < 2'd2) || deq_s;
    fetch_s        = (state_q == RUN) && !i_redirect_valid && pc_in_range(pc_q) && has_slot_s;
    range_fault_s  = (state_q == RUN) && !i_redirect_valid && !pc_in_range(pc_q) && has_slot_s;
    push_entry_s   = '{pc: pc_q, instr: i_imem_instr};
  end

  // FSM next state and PC update; a bad redirect target leaves the PC alone
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_bad_s) begin
      state_d = FAULT;
    end else if (redirect_ok_s && (state_q == FAULT)) begin
      state_d = i_enable ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = i_enable ? RUN : IDLE;
        RUN: begin
          if (range_fault_s) begin
            state_d = FAULT;
          end else begin
            state_d = i_enable ? RUN : IDLE;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
    if (redirect_ok_s) begin
      pc_d = i_redirect_pc;
    end else if (fetch_s) begin
      pc_d = pc_q + DATA_WIDTH'(PC_STEP);
    end else begin
      pc_d = pc_q;
    end
  end

  // state and PC registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue u_queue (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .push       (fetch_s),
    .pop        (deq_s),
    .flush      (i_redirect_valid),
    .push_entry (push_entry_s),
    .count      (q_count_s),
    .head       (head_s)
  );

  assign o_imem_addr = pc_q;
  assign o_valid     = (q_count_s != 2'd0);
  assign o_instr     = o_valid ? head_s.instr : INSTR_NOP;
  assign o_pc        = o_valid ? head_s.pc : {DATA_WIDTH{1'b0}};
  assign o_fault     = (state_q == FAULT);

  fetch_sequencer_checker #(
    .DATA_WIDTH  (DATA_WIDTH),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_checker (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .valid     (o_valid),
    .instr     (o_instr),
    .imem_addr (o_imem_addr),
    .count     (q_count_s)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a behavioural ROM
// where word n holds 0x2008_0000 + n + 1.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fault;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always_comb imem_instr = 32'h2008_0000 + (imem_addr >> 2) + 32'd1;

  fetch_sequencer dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_enable         (enable),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_addr      (imem_addr),
    .i_imem_instr     (imem_instr),
    .o_valid          (valid),
    .i_ready          (ready),
    .o_instr          (instr),
    .o_pc             (pc),
    .o_fault          (fault)
  );

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    bit          ef;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit en, input bit rdy, input bit rv,
                     input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                     input logic [31:0] einstr, input bit ef, input logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.ef = ef; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_outputs(input string tag, input bit ev, input logic [31:0] epc,
                             input logic [31:0] einstr, input bit ef, input logic [31:0] eaddr);
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".pc"},    pc, epc);
    chk({tag, ".instr"}, instr, einstr);
    chk({tag, ".fault"}, 32'(fault), 32'(ef));
    chk({tag, ".addr"},  imem_addr, eaddr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0; ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: streaming, then pause (RUN fetches once more while leaving) and drain
    add(1, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h00);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h00);
    add(0, 1, 1, 0, 32'h00, 1, 32'h00, 32'h2008_0001, 0, 32'h04);
    add(0, 1, 1, 0, 32'h00, 1, 32'h04, 32'h2008_0002, 0, 32'h08);
    add(0, 1, 1, 0, 32'h00, 1, 32'h08, 32'h2008_0003, 0, 32'h0C);
    add(0, 1, 1, 0, 32'h00, 1, 32'h0C, 32'h2008_0004, 0, 32'h10);
    add(0, 0, 1, 0, 32'h00, 1, 32'h10, 32'h2008_0005, 0, 32'h14);
    add(0, 0, 1, 0, 32'h00, 1, 32'h14, 32'h2008_0006, 0, 32'h18);
    add(0, 0, 1, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h18);
    // 2: backpressure for five cycles, then release
    add(1, 1, 0, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h00);
    add(0, 1, 0, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h00);
    add(0, 1, 0, 0, 32'h00, 1, 32'h00, 32'h2008_0001, 0, 32'h04);
    add(0, 1, 0, 0, 32'h00, 1, 32'h00, 32'h2008_0001, 0, 32'h08);
    add(0, 1, 0, 0, 32'h00, 1, 32'h00, 32'h2008_0001, 0, 32'h08);
    add(0, 1, 1, 0, 32'h00, 1, 32'h00, 32'h2008_0001, 0, 32'h08);
    add(0, 1, 1, 0, 32'h00, 1, 32'h04, 32'h2008_0002, 0, 32'h0C);
    add(0, 1, 1, 0, 32'h00, 1, 32'h08, 32'h2008_0003, 0, 32'h10);
    // 3: redirect to 0x40 with a full queue; 5: misaligned redirect, recovery
    add(1, 1, 0, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h00);
    add(0, 1, 0, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h00);
    add(0, 1, 0, 0, 32'h00, 1, 32'h00, 32'h2008_0001, 0, 32'h04);
    add(0, 1, 1, 1, 32'h40, 1, 32'h00, 32'h2008_0001, 0, 32'h08);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h40);
    add(0, 1, 1, 0, 32'h00, 1, 32'h40, 32'h2008_0011, 0, 32'h44);
    add(0, 1, 1, 1, 32'h12, 1, 32'h44, 32'h2008_0012, 0, 32'h48);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         1, 32'h48);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         1, 32'h48);
    add(0, 1, 1, 1, 32'h10, 0, 32'h00, 32'h0,         1, 32'h48);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h10);
    add(0, 1, 1, 0, 32'h00, 1, 32'h10, 32'h2008_0005, 0, 32'h14);
    // 4: range fault at 0x80, out-of-range redirect ignored, valid redirect recovers
    add(1, 1, 1, 1, 32'h74, 0, 32'h00, 32'h0,         0, 32'h00);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h74);
    add(0, 1, 1, 0, 32'h00, 1, 32'h74, 32'h2008_001E, 0, 32'h78);
    add(0, 1, 1, 0, 32'h00, 1, 32'h78, 32'h2008_001F, 0, 32'h7C);
    add(0, 1, 1, 0, 32'h00, 1, 32'h7C, 32'h2008_0020, 0, 32'h80);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         1, 32'h80);
    add(0, 1, 1, 1, 32'h200,0, 32'h00, 32'h0,         1, 32'h80);
    add(0, 1, 1, 1, 32'h10, 0, 32'h00, 32'h0,         1, 32'h80);
    add(0, 1, 1, 0, 32'h00, 0, 32'h00, 32'h0,         0, 32'h10);
    add(0, 1, 1, 0, 32'h00, 1, 32'h10, 32'h2008_0005, 0, 32'h14);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      enable         = vecs[i].en;
      ready          = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #2;
      chk_outputs($sformatf("row%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                  vecs[i].ef, vecs[i].eaddr);
      @(posedge clk);
      #1;
    end

    // 6: asynchronous reset with a full queue, then refetch from RESET_PC
    do_reset();
    enable = 1'b1; ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_outputs("full_before_rst", 1'b1, 32'h00, 32'h2008_0001, 1'b0, 32'h08);
    rst_n = 1'b0;
    #2;
    chk_outputs("async_rst", 1'b0, 32'h00, 32'h0, 1'b0, 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    chk_outputs("post_rst_idle", 1'b0, 32'h00, 32'h0, 1'b0, 32'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk_outputs("refetch", 1'b1, 32'h00, 32'h2008_0001, 1'b0, 32'h04);
    @(posedge clk);
    #1;
    chk_outputs("refetch_next", 1'b1, 32'h04, 32'h2008_0002, 1'b0, 32'h08);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
